base64_tx_serializer: RTL and testbench
=======================================

// Module: base64_tx_serializer
// PURPOSE
//  Downstream stage of the base64 transform block. Captures one 5120-bit encoded block
//  (640 base64 ASCII chars) when the transform raises finish, and acknowledges it with a
//  one-cycle read pulse. Then streams the block out one char per beat on a valid/ready
//  byte interface towards the network TX path.
// PARAMETERS
//  CHARS   640   chars per block; block width = CHARS*CW
//  CW      8     bits per char
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rst        in   1            synchronous, active-high reset
//  finish     in   1            transform has a complete block on data_in
//  data_in    in   CHARS*CW     encoded block; char k = data_in[CW*k+CW-1:CW*k]
//  read       out  1            one-cycle pulse: block consumed, transform may return to IDLE
//  out_data   out  CW           current char
//  out_valid  out  1            out_data valid
//  out_ready  in   1            sink accepts char when out_valid & out_ready
//  out_last   out  1            high with the char k=CHARS-1
//  busy       out  1            block held (state SEND)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, read=0, out_valid=0, out_last=0, out_data=0,
//   busy=0, beat count=0, shift reg=0, armed=0. Mid-stream reset drops the block; the
//   remaining chars are never sent and no read pulse is issued.
//  armed: set on any cycle with finish=0; cleared on capture. This prevents a finish that
//   is still high after read (transform clears it late) from recapturing the same block.
//  FSM, 2 states:
//   IDLE: if finish & armed at posedge T: shreg<=data_in, count<=0, armed<=0, read<=1
//         (for cycle T+1 only), state<=SEND. Otherwise hold.
//   SEND: out_valid=1, out_data=shreg[CW-1:0], out_last=(count==CHARS-1), busy=1.
//         On a handshake: shreg shifts right by CW; count increments.
//         If the handshake occurs at count==CHARS-1: state<=IDLE, count<=0.
//         finish is ignored in SEND (armed still tracks finish=0).
//  Latency: the first char is valid in cycle T+1, the same cycle as the read pulse.
//   With out_ready held high, the last char is accepted in cycle T+CHARS and out_valid=0
//   in cycle T+CHARS+1.
//  Backpressure: while out_valid & !out_ready, out_data, out_last and count hold stable.
//   out_valid never drops before the handshake.
//  count width = $clog2(CHARS); it never exceeds CHARS-1.
//  read is registered, high at most one cycle per captured block.
//  Back-to-back blocks: a new capture needs IDLE, armed and finish. The minimum gap
//   between the last handshake and the next first char is 1 idle cycle plus the
//   finish low->high time.
//  out_* are registered or decoded from registered state only; no comb path from
//   out_ready to out_valid.
// TESTING
//  1 Block data_in char k = k%256, finish high, out_ready=1 -> read high exactly 1 cycle;
//    640 beats with out_data 0x00,0x01,...,0x7F(k=639); out_last only on beat 640.
//  2 Same block, out_ready toggled 1/0 plus 10-cycle stalls -> chars unchanged, no
//    duplicates or drops, out_data stable during stalls, exactly 640 handshakes.
//  3 finish kept high for 700 cycles after the read pulse -> no second capture. finish low
//    1 cycle then high -> second block captured and streamed.
//  4 Finish pulsed again during SEND with a different data_in -> ignored. The stream keeps
//    the first block; the second is captured after the return to IDLE, given armed.
//  5 rst asserted at beat 300 -> next cycle out_valid=0, read=0, busy=0. A following block
//    streams from char 0.
//  6 All-'A' (0x41) block, out_ready=1 continuously -> 640 beats of 0x41; out_valid drops
//    in cycle T+641 after capture at T.

Source files
------------

// File: rtl/base64_tx_serializer.sv
// base64_tx_serializer: captures one encoded block on finish and streams it out one char per valid/ready beat
module base64_tx_serializer #(
  parameter int CHARS = 640,
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  finish,
  input  logic [CHARS*CW-1:0]   data_in,
  output logic                  read,
  output logic [CW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);
  localparam int CNTW = $clog2(CHARS);
  localparam logic [CNTW-1:0] LAST = CNTW'(CHARS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t               state_q;
  logic [CHARS*CW-1:0]  shreg_q;
  logic [CNTW-1:0]      count_q;
  logic                 armed_q;
  logic                 read_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      armed_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      read_q <= 1'b0;
      // armed only re-arms once finish has been seen low, so a late-clearing finish cannot recapture
      if (!finish) armed_q <= 1'b1;
      if (state_q == IDLE) begin
        if (finish && armed_q) begin
          shreg_q <= data_in;
          count_q <= '0;
          armed_q <= 1'b0;
          read_q  <= 1'b1;
          state_q <= SEND;
        end
      end else if (out_ready) begin
        shreg_q <= shreg_q >> CW;
        count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
        if (count_q == LAST) state_q <= IDLE;
      end
    end
  end
  assign out_valid = state_q == SEND;
  assign busy      = out_valid;
  assign out_data  = shreg_q[CW-1:0];
  assign out_last  = out_valid && count_q == LAST;
  assign read      = read_q;
endmodule

// File: tb/tb_base64_tx_serializer.sv
// tb_base64_tx_serializer: randomized stimulus checked every cycle against a queue-based block model
module tb_base64_tx_serializer;
  localparam int CHARS = 640;
  localparam int CW = 8;
  localparam int W = CHARS * CW;
  logic clk = 0, rst = 1, finish = 0, out_ready = 0;
  logic [W-1:0] data_in = '0;
  logic read, out_valid, out_last, busy;
  logic [CW-1:0] out_data;
  int checks = 0, errors = 0;
  byte unsigned mq[$];
  byte unsigned acc[$];
  bit m_armed = 0, m_read = 0;
  int reads = 0;
  logic [W-1:0] blk_a, blk_b;

  base64_tx_serializer #(.CHARS(CHARS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .finish(finish), .data_in(data_in), .read(read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending-char queue; a block is loaded whole on capture and popped per accepted beat
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_armed = 0;
      m_read = 0;
    end else begin
      if (out_valid && out_ready) acc.push_back(out_data);
      if (read) reads++;
      m_read = 0;
      if (mq.size() == 0) begin
        if (finish && m_armed) begin
          for (int k = 0; k < CHARS; k++) mq.push_back(data_in[CW*k +: CW]);
          m_armed = 0;
          m_read = 1;
        end
      end else if (out_ready) begin
        void'(mq.pop_front());
      end
      if (!finish) m_armed = 1;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    chk("busy", int'(busy), int'(mq.size() != 0));
    chk("read", int'(read), int'(m_read));
    if (mq.size() != 0) begin
      chk("out_data", int'(out_data), int'(mq[0]));
      chk("out_last", int'(out_last), int'(mq.size() == 1));
    end else begin
      chk("out_last_idle", int'(out_last), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    int stall = 0;
    do begin
      @(negedge clk);
      n++;
      if (rnd) begin
        if (stall > 0) begin
          out_ready = 0;
          stall--;
        end else begin
          out_ready = 1'($urandom % 2);
          if ($urandom % 40 == 0) stall = 10;
        end
      end
    end while (busy && n < budget);
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic fill_seq();
    for (int k = 0; k < CHARS; k++) data_in[CW*k +: CW] = CW'(k % 256);
  endtask

  task automatic fill_rand(output logic [W-1:0] b);
    for (int k = 0; k < CHARS; k++) b[CW*k +: CW] = CW'($urandom);
  endtask

  task automatic clear_log();
    acc.delete();
    reads = 0;
  endtask

  initial begin
    int n;
    int bad;
    tick(3);
    chk("rst_data", int'(out_data), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst = 0;
    tick(2);
    // 1: counting block, ready high
    fill_seq();
    out_ready = 1;
    finish = 1;
    wait_idle(2000, 0);
    chk("t1_beats", acc.size(), 640);
    chk("t1_c0", int'(acc[0]), 8'h00);
    chk("t1_c255", int'(acc[255]), 8'hFF);
    chk("t1_c639", int'(acc[639]), 8'h7F);
    chk("t1_reads", reads, 1);
    finish = 0;
    tick(2);
    clear_log();
    // 2: random backpressure with stalls
    finish = 1;
    wait_idle(6000, 0);
    finish = 0;
    chk("t2_beats", acc.size(), 640);
    clear_log();
    tick(1);
    finish = 1;
    wait_idle(8000, 1);
    chk("t2r_beats", acc.size(), 640);
    chk("t2r_c300", int'(acc[300]), 300 % 256);
    chk("t2r_c639", int'(acc[639]), 8'h7F);
    out_ready = 1;
    // 3: finish held high long after read must not recapture
    finish = 0;
    tick(2);
    clear_log();
    finish = 1;
    tick(700);
    chk("t3_reads", reads, 1);
    chk("t3_beats", acc.size(), 640);
    chk("t3_busy", int'(busy), 0);
    fill_rand(blk_b);
    data_in = blk_b;
    finish = 0;
    tick(1);
    finish = 1;
    wait_idle(2000, 0);
    chk("t3_reads2", reads, 2);
    chk("t3_beats2", acc.size(), 1280);
    chk("t3_b0", int'(acc[640]), int'(blk_b[7:0]));
    finish = 0;
    tick(2);
    clear_log();
    // 4: finish re-pulsed during SEND with different data
    fill_rand(blk_a);
    fill_rand(blk_b);
    data_in = blk_a;
    finish = 1;
    tick(5);
    finish = 0;
    tick(1);
    data_in = blk_b;
    finish = 1;
    wait_idle(8000, 1);
    wait_idle(8000, 1);
    out_ready = 1;
    finish = 0;
    chk("t4_reads", reads, 2);
    chk("t4_beats", acc.size(), 1280);
    chk("t4_a5", int'(acc[5]), int'(blk_a[CW*5 +: CW]));
    chk("t4_a639", int'(acc[639]), int'(blk_a[CW*639 +: CW]));
    chk("t4_b5", int'(acc[645]), int'(blk_b[CW*5 +: CW]));
    tick(2);
    clear_log();
    // 5: reset mid-stream at beat 300
    fill_seq();
    finish = 1;
    n = 0;
    while (acc.size() < 300 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("t5_reach300", acc.size(), 300);
    rst = 1;
    finish = 0;
    tick(1);
    rst = 0;
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_read", int'(read), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_data", int'(out_data), 0);
    tick(2);
    chk("t5_no_more", acc.size(), 300);
    fill_rand(blk_a);
    data_in = blk_a;
    finish = 1;
    wait_idle(2000, 0);
    chk("t5_beats", acc.size(), 940);
    chk("t5_new0", int'(acc[300]), int'(blk_a[7:0]));
    finish = 0;
    tick(2);
    clear_log();
    // 6: all-'A' block, valid for exactly 640 cycles after capture
    data_in = {CHARS{8'h41}};
    finish = 1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!read && n < 10);
    chk("t6_read", int'(read), 1);
    n = 0;
    while (out_valid && n < 2000) begin
      tick(1);
      n++;
    end
    chk("t6_valid_cycles", n, 640);
    bad = 0;
    foreach (acc[i]) if (acc[i] != 8'h41) bad++;
    chk("t6_beats", acc.size(), 640);
    chk("t6_allA", bad, 0);
    finish = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
